// File: rtl/apb_pkg.sv
// Shared APB constants: bus widths, FSM state encoding and the fixed register indices.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam int REG_ID  = 0;
  localparam int REG_CNT = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x 32 register storage with one write port and one async read port.
// Word 0 reads a constant ID, word 1 reads the transfer counter; both are read-only.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001,
  parameter int          ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [APB_DW-1:0] wdata_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [APB_DW-1:0] rdata_o
);

  logic [APB_DW-1:0] mem_q [DEPTH];
  logic [APB_DW-1:0] cnt_q;
  logic              wr_ro;

  assign wr_ro = (waddr_i == ADDR_W'(REG_ID)) || (waddr_i == ADDR_W'(REG_CNT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i && !wr_ro) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Counts every completed transfer, errored or not; wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (raddr_i == ADDR_W'(REG_ID))  rdata_o = ID_VALUE;
    if (raddr_i == ADDR_W'(REG_CNT)) rdata_o = cnt_q;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder over a small register file; Pready after WAIT_STATES extra access cycles,
// errors on Pslverr; aborts cleanly if the master drops Pselx/Penable during access.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          SLAVE_IDX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic [2:0]        Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [APB_AW-1:0] Paddr,
  input  logic [APB_DW-1:0] Pwdata,
  output logic [APB_DW-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr
);

  localparam int ADDR_W = $clog2(DEPTH);

  apb_state_e        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              err_q, err_d;

  logic              sel;
  logic              done;
  logic              setup_err;
  logic [ADDR_W-1:0] paddr_idx;
  logic [APB_DW-1:0] rd_data;
  logic              unused_sel;

  assign sel        = Pselx[SLAVE_IDX];
  assign unused_sel = ^Pselx;
  assign paddr_idx  = Paddr[ADDR_W+1:2];

  assign setup_err = (Paddr[1:0] != 2'b00)
                  || (Paddr[APB_AW-1:ADDR_W+2] != BASE_ADDR[APB_AW-1:ADDR_W+2])
                  || (Pwrite && ((paddr_idx == ADDR_W'(REG_ID)) ||
                                 (paddr_idx == ADDR_W'(REG_CNT))));

  assign done    = (state_q == ST_ACCESS) && (wait_q == 4'd0) && sel && Penable;
  assign Pready  = done;
  assign Pslverr = done && err_q;
  assign Prdata  = prdata_q;

  apb_regfile_mem #(
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk_i   (Hclk),
    .rst_i   (Hreset),
    .we_i    (done && wr_q && !err_q),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .inc_i   (done),
    .raddr_i (paddr_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        // Penable without a preceding setup cycle is ignored.
        if (sel && !Penable) begin
          state_d  = ST_ACCESS;
          wr_d     = Pwrite;
          idx_d    = paddr_idx;
          wdata_d  = Pwdata;
          wait_d   = 4'(WAIT_STATES);
          err_d    = setup_err;
          prdata_d = (!Pwrite && !setup_err) ? rd_data : '0;
        end
      end
      ST_ACCESS: begin
        if (!sel || !Penable) begin
          state_d  = ST_IDLE;
          prdata_d = '0;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          state_d  = ST_IDLE;
          prdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Two responders on one APB bus (slave 0: no wait states, slave 1: three) plus an empty select line,
// checked against a word-array model of the register map.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;
  localparam int          NW   = 16;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata_v [2];
  logic [1:0]  pready_v;
  logic [1:0]  pslverr_v;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [2][NW];
  logic [31:0] m_cnt [2];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.SLAVE_IDX(0), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_v[0]), .Pready(pready_v[0]), .Pslverr(pslverr_v[0])
  );

  apb_slave_regfile #(.SLAVE_IDX(1), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_STATES(3), .ID_VALUE(ID)) dut1 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_v[1]), .Pready(pready_v[1]), .Pslverr(pslverr_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * NW);
  endfunction

  function automatic bit model_err(input logic [31:0] a, input bit wr);
    if (a % 4 != 0) return 1'b1;
    if (!in_window(a)) return 1'b1;
    if (wr && ((a - BASE) / 4) < 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      for (int i = 0; i < NW; i++) m_mem[s][i] = 0;
    end
  endtask

  task automatic bus_idle();
    @(posedge Hclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
  endtask

  // One complete APB transfer starting at the next rising edge; s==2 targets the empty select.
  task automatic xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd);
    bit          e;
    int          w;
    int          waits;
    bit          got;
    logic [31:0] erd;
    rd = '0;
    @(posedge Hclk); #1;
    Pselx = 3'(1 << s); Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = wd;
    @(negedge Hclk);
    check("setup_rdy", {30'b0, pready_v}, 0);
    if (s == 2) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(negedge Hclk);
        check("unsel_rdy", {30'b0, pready_v}, 0);
      end
      return;
    end
    e   = model_err(a, wr);
    w   = in_window(a) ? int'((a - BASE) / 4) : 0;
    erd = (wr || e) ? 32'h0 : (w == 0) ? ID : (w == 1) ? m_cnt[s] : m_mem[s][w];
    @(posedge Hclk); #1;
    Penable = 1'b1;
    Pwdata  = $urandom;
    waits = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge Hclk);
      if (pready_v[s]) got = 1'b1;
      else begin
        waits++;
        @(posedge Hclk); #1;
      end
    end
    check("timeout", {31'b0, got}, 1);
    check("latency", waits, ws_of(s));
    check("slverr", {31'b0, pslverr_v[s]}, {31'b0, e});
    check("prdata", prdata_v[s], erd);
    check("other_rdy", {31'b0, pready_v[1-s]}, 0);
    rd = prdata_v[s];
    if (wr && !e) m_mem[s][w] = wd;
    m_cnt[s] = m_cnt[s] + 1;
  endtask

  initial begin
    logic [31:0] rd;
    Hreset = 1'b1; Pselx = 0; Penable = 0; Pwrite = 0; Paddr = 0; Pwdata = 0;
    model_reset();
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    for (int s = 0; s < 2; s++) begin
      check("rst_rdy", {31'b0, pready_v[s]}, 0);
      check("rst_err", {31'b0, pslverr_v[s]}, 0);
      check("rst_prdata", prdata_v[s], 0);
    end
    @(posedge Hclk); #1;
    Hreset = 1'b0;

    // Write/read-back, counter and ID on the zero-wait slave.
    xfer(0, 1, BASE + 32'h8, 32'hDEAD_BEEF, rd);
    xfer(0, 0, BASE + 32'h8, 32'h0, rd);
    check("readback", rd, 32'hDEAD_BEEF);
    xfer(0, 0, BASE + 32'h4, 32'h0, rd);
    check("cnt_word", rd, 32'h2);
    xfer(0, 0, BASE, 32'h0, rd);
    check("id_word", rd, ID);

    // Error responses leave storage alone but are counted.
    xfer(0, 1, BASE, 32'h1111_1111, rd);
    xfer(0, 1, BASE + 32'h9, 32'h2222_2222, rd);
    xfer(0, 1, 32'h9000_0008, 32'h3333_3333, rd);
    xfer(0, 0, BASE + 32'h8, 32'h0, rd);
    check("err_nowrite", rd, 32'hDEAD_BEEF);
    xfer(0, 0, BASE + 32'h4, 32'h0, rd);
    check("err_counted", rd, 32'h8);
    bus_idle();

    // Wait-state slave.
    xfer(1, 1, BASE + 32'hC, 32'hCAFE_F00D, rd);
    xfer(1, 0, BASE + 32'hC, 32'h0, rd);
    check("ws_readback", rd, 32'hCAFE_F00D);
    bus_idle();

    // Abort mid-access: select dropped after one Penable cycle.
    @(posedge Hclk); #1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h10; Pwdata = 32'h5555_AAAA;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    @(negedge Hclk);
    check("abort_rdy0", {31'b0, pready_v[1]}, 0);
    @(posedge Hclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
    @(negedge Hclk);
    check("abort_rdy1", {31'b0, pready_v[1]}, 0);
    xfer(1, 0, BASE + 32'h10, 32'h0, rd);
    check("abort_nowrite", rd, 32'h0);

    // Back-to-back traffic with the empty select interleaved.
    xfer(0, 1, BASE + 32'h14, 32'h0BAD_CAFE, rd);
    xfer(2, 1, BASE + 32'h14, 32'hFFFF_0000, rd);
    xfer(1, 0, BASE + 32'hC, 32'h0, rd);
    xfer(0, 0, BASE + 32'h14, 32'h0, rd);
    check("b2b_read", rd, 32'h0BAD_CAFE);
    xfer(2, 0, BASE, 32'h0, rd);
    xfer(1, 1, BASE + 32'h8, 32'h1234_5678, rd);
    xfer(0, 1, BASE + 32'h3C, 32'h8765_4321, rd);
    bus_idle();

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int          s;
      int          kind;
      bit          wr;
      logic [31:0] a;
      s    = $urandom_range(0, 2);
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = BASE + 4 * $urandom_range(0, NW - 1) + $urandom_range(1, 3);
      else if (kind == 1) a = BASE + 4 * NW + 4 * $urandom_range(0, 1000);
      else if (kind == 2) a = {4'h1, 28'($urandom)} & 32'hFFFF_FFFC;
      else                a = BASE + 4 * $urandom_range(0, NW - 1);
      xfer(s, wr, a, $urandom, rd);
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();

    // Reset in the middle of a wait-state write.
    @(posedge Hclk); #1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h8; Pwdata = 32'h7777_7777;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    #1;
    check("rstmid_rdy", {31'b0, pready_v[1]}, 0);
    check("rstmid_err", {31'b0, pslverr_v[1]}, 0);
    check("rstmid_prdata", prdata_v[1], 0);
    Pselx = 3'b000; Penable = 1'b0;
    model_reset();
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    xfer(1, 0, BASE + 32'h8, 32'h0, rd);
    check("rstmid_word2", rd, 32'h0);
    xfer(0, 0, BASE + 32'h4, 32'h0, rd);
    check("rstmid_cnt", rd, 32'h0);
    bus_idle();
    repeat (3) @(posedge Hclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB responder at the peripheral end of the AHB-to-APB bridge; answers transfers issued by the bridge's APB controller on one Pselx line. It holds a DEPTH-word 32-bit register file with a read-only ID word and a read-only transfer counter. Wait states are programmable and signalled on Pready; errors are signalled on Pslverr. With WAIT_STATES=0 it completes in the bridge's fixed two-cycle setup/enable sequence.

Parameters:
SLAVE_IDX, 0, which Pselx bit selects this slave (0..2)
BASE_ADDR, 32'h8000_0000, window base; Paddr[31:ADDR_W+2] must equal BASE_ADDR[31:ADDR_W+2]
DEPTH, 16, number of 32-bit words (power of 2, >=4); ADDR_W = log2(DEPTH)
WAIT_STATES, 0, extra access cycles before Pready (0..15)
ID_VALUE, 32'hA5B0_0001, constant returned by word 0

Ports:
Hclk  in  1  clock
Hreset  in  1  asynchronous, active-high reset
Pselx  in  3  slave selects; only bit SLAVE_IDX used
Penable  in  1  APB enable (access phase)
Pwrite  in  1  1=write, 0=read
Paddr  in  32  byte address
Pwdata  in  32  write data
Prdata  out  32  read data, valid while Pready=1 on a read
Pready  out  1  transfer complete this cycle
Pslverr  out  1  error response, qualified by Pready

Behaviour:
- Reset (async, Hreset=1): state IDLE, wait counter 0, Prdata 0, Pready 0, Pslverr 0, words 2..DEPTH-1 = 0, transfer counter (word 1) = 0.
- sel = Pselx[SLAVE_IDX]. FSM states: IDLE, ACCESS.
- IDLE: on sel && !Penable (setup phase), latch Pwrite, word index Paddr[ADDR_W+1:2], Pwdata; load counter = WAIT_STATES; compute err; go ACCESS. Penable=1 without prior setup is ignored.
- err = Paddr[1:0]!=0, or upper address bits outside window, or write to word 0 or word 1.
- In the setup cycle, on a read without err, the read word is registered into Prdata (visible in ACCESS); on err or a write, Prdata loads 0.
- ACCESS: if !sel or !Penable -> abort to IDLE: no write, no count, Pready stays 0. Else if counter!=0 -> decrement, stay. Else (counter==0) -> Pready=1 this cycle, Pslverr=err; on the closing edge perform write (if Pwrite && !err), increment transfer counter (wraps 32'hFFFF_FFFF -> 0, counts errored transfers too), clear Prdata, go IDLE.
- Pready and Pslverr are decoded from registered state only (state==ACCESS && counter==0 && sel && Penable); never asserted in IDLE.
- Back-to-back: setup of the next transfer in the cycle after Pready is accepted from IDLE; no dead cycle required. Latency: WAIT_STATES=0 -> Pready in the 2nd cycle (Penable cycle); each wait state adds one.
- Write data uses Pwdata latched at setup; Pwdata changes during ACCESS are ignored. Read of word 0 returns ID_VALUE; word 1 returns the counter value at setup.
- Reset mid-transfer: immediate return to IDLE; the pending write is lost.

Decomposition:
- Shared package apb_pkg: state encoding constants (ST_IDLE, ST_ACCESS), APB data/address width constants, register index constants (REG_ID=0, REG_CNT=1).
- One sub-module: apb_regfile_mem (DEPTH x 32 storage, one write port, one async read port, RO decode for words 0/1, transfer counter). The FSM and wait counter stay in the top module.

Test Plan:
- Reset then read word 0 (Paddr=32'h8000_0000), WAIT_STATES=0 -> Pready=1 in the Penable cycle, Prdata=32'hA5B0_0001, Pslverr=0.
- Write 32'hDEAD_BEEF to 32'h8000_0008, then read it back -> Prdata=32'hDEAD_BEEF; a following read of word 1 returns 32'h0000_0002.
- WAIT_STATES=3, write to 32'h8000_000C -> Pready low for 3 Penable cycles, high on the 4th; data is written only after that edge.
- Write to word 0, misaligned 32'h8000_0009, out-of-window 32'h9000_0008 -> each gives Pslverr=1 with Pready=1 and leaves storage unchanged; the transfer counter still increments.
- WAIT_STATES=2, drop Pselx mid-ACCESS -> no Pready and no write. Assert Hreset mid-ACCESS -> outputs 0 immediately and word 2 reads 0 afterwards.
- Back-to-back write/read/write with no idle cycle, with Pselx bit != SLAVE_IDX interleaved -> correct data; the unselected transfers get no response.
